// File: rtl/hog_pkg.sv
// Shared types and defaults for the HOG pixel sender.
package hog_pkg;

    localparam int PIX_W = 8;
    localparam int IN_W  = PIX_W * 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/hog_pix_sender_if.sv
// Control, SRAM and stream signals between the sender and its neighbours.
interface hog_pix_sender_if #(
    parameter int IN_W   = 32,
    parameter int ADDR_W = 17
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [IN_W-1:0]   mem_rdata;
    logic [IN_W-1:0]   i_data;
    logic              i_valid;
    logic              ready;
    logic              o_eol;
    logic              o_last;

    modport master (
        input  start, mem_rdata, ready,
        output busy, done, mem_rd_en, mem_addr,
        output i_data, i_valid, o_eol, o_last
    );

    modport slave (
        output start, mem_rdata, ready,
        input  busy, done, mem_rd_en, mem_addr,
        input  i_data, i_valid, o_eol, o_last
    );
endinterface

// File: rtl/hog_skid_fifo.sv
// Two-entry skid FIFO that absorbs the one-cycle SRAM read latency.
module hog_skid_fifo
    import hog_pkg::*;
#(
    parameter int W = IN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rptr;
    logic         wptr;
    logic         do_pop;
    logic         do_push;

    assign full    = (occ == 2'd2);
    assign empty   = (occ == 2'd0);
    assign head    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/hog_pix_sender.sv
// Streams a stored frame from word SRAM to the HOG core over valid/ready.
module hog_pix_sender #(
    parameter int  PIX_W  = hog_pkg::PIX_W,
    parameter int  IMG_W  = 640,
    parameter int  IMG_H  = 480,
    localparam int IN_W   = PIX_W * 4,
    localparam int WPR    = IMG_W / 4,
    localparam int NWORD  = WPR * IMG_H,
    localparam int ADDR_W = $clog2(NWORD)
) (
    input logic              clk,
    input logic              rst,
    hog_pix_sender_if.master bus
);
    import hog_pkg::*;

    localparam int CW = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NWORD - 1);
    localparam logic [CW-1:0]     LAST_C = CW'(WPR - 1);

    state_t            state;
    state_t            nstate;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] wcnt;
    logic [CW-1:0]     col;
    logic              outstanding;
    logic              done_q;
    logic              pop;
    logic              rd_en;
    logic              start_ok;
    logic              full;
    logic              empty;
    logic [1:0]        occ;
    logic [IN_W-1:0]   head;
    logic [2:0]        fill;

    hog_skid_fifo #(.W(IN_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (outstanding),
        .pop   (pop),
        .wdata (bus.mem_rdata),
        .full  (full),
        .empty (empty),
        .occ   (occ),
        .head  (head)
    );

    // Words in the buffer or on their way must stay below two after this pop.
    assign fill     = {1'b0, occ} + {2'b0, outstanding};
    assign pop      = bus.i_valid && bus.ready;
    assign rd_en    = (state == RUN) && (fill < 3'd2 + {2'b0, pop});
    assign start_ok = (state == IDLE) && bus.start && !done_q;

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start_ok) nstate = RUN;
            RUN:     if (rd_en && raddr == LAST_A) nstate = DRAIN;
            DRAIN:   if (pop && bus.o_last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr       <= '0;
            wcnt        <= '0;
            col         <= '0;
            outstanding <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            outstanding <= rd_en;
            done_q      <= (state == DRAIN) && pop && bus.o_last;
            if (start_ok) begin
                raddr <= '0;
                wcnt  <= '0;
                col   <= '0;
            end else begin
                if (rd_en) raddr <= raddr + ADDR_W'(1);
                if (pop) begin
                    wcnt <= wcnt + ADDR_W'(1);
                    col  <= (col == LAST_C) ? '0 : col + CW'(1);
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = raddr;
    assign bus.i_valid   = !empty;
    assign bus.i_data    = head;
    assign bus.o_eol     = bus.i_valid && (col == LAST_C);
    assign bus.o_last    = bus.i_valid && (wcnt == LAST_A);

    ap_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(outstanding && full && !pop)
    );

endmodule

// File: doc/hog_pix_sender.md
# hog_pix_sender

Frame-level pixel transmitter that feeds the HOG feature core. It reads a stored grey-scale frame from a word-addressed SRAM, where each word holds 4 packed pixels. It then streams the words over a valid/ready link into the core's `i_data`/`i_valid` input. A 2-entry skid buffer hides the SRAM read latency so that, under backpressure, data is never dropped and no extra reads are issued.

## Interface
Parameters:
- `PIX_W`, 8, pixel width in bits.
- `IMG_W`, 640, frame width in pixels; must be a multiple of 4.
- `IMG_H`, 480, frame height in rows.
- localparam `IN_W` = PIX_W*4, stream and SRAM word width.
- localparam `WPR` = IMG_W/4, words per row.
- localparam `NWORD` = WPR*IMG_H, words per frame.
- localparam `ADDR_W` = $clog2(NWORD).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins one frame; ignored while `busy`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse, frame fully transferred.
- `mem_rd_en`  out  1  SRAM read strobe.
- `mem_addr`  out  ADDR_W  SRAM word address.
- `mem_rdata`  in  IN_W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `i_data`  out  IN_W  pixel word to the HOG core; pixel 0 is in LSBs.
- `i_valid`  out  1  `i_data` valid.
- `ready`  in  1  core accepts; a transfer occurs when `i_valid && ready`.
- `o_eol`  out  1  qualifies `i_data`: last word of a row.
- `o_last`  out  1  qualifies `i_data`: last word of the frame.

## Operation
- FSM states:
  - IDLE to RUN on `start`. Clears the read address counter `raddr`, the output word counter, and the column counter.
  - RUN to DRAIN in the cycle the read for address NWORD-1 issues.
  - DRAIN to IDLE on the handshake of the `o_last` word. `done` pulses in the following cycle.
- Read issue rule:
  - `mem_rd_en` = (state==RUN) && (occ + outstanding − pop < 2).
  - `occ` is the FIFO fill count (0..2), `outstanding` is the read issued in the previous cycle (0/1), and `pop` = `i_valid && ready`.
  - `mem_addr` = `raddr`, which increments on each issued read.
- `mem_rdata` is pushed into the FIFO in the cycle after each read. By construction the FIFO never overflows; overflow is a design error and carries an assertion.
- Output side:
  - `i_valid` = FIFO non-empty. `i_data` is the FIFO head.
  - `i_data`, `o_eol` and `o_last` are held stable while `i_valid && !ready`.
- Flags are generated from the output-side counters, not the address:
  - `o_eol` = (col == WPR−1).
  - `o_last` = (word count == NWORD−1).
  - col wraps to 0 after each row.
- `start` while `busy` has no effect, including in the same cycle as `done`.
- Reset, including mid-frame:
  - All outputs go to 0, the FSM returns to IDLE and the FIFO empties.
  - An SRAM read in flight at reset is discarded.

## Timing
- The `start` edge is k.
  - Cycle k+1: `busy`=1, `mem_rd_en`=1, `mem_addr`=0.
  - Cycle k+2: data is captured.
  - Cycle k+3: first `i_valid`.
- With `ready` held high, throughput is one word per cycle. The last handshake occurs at cycle k+2+NWORD and `done` pulses at k+3+NWORD.
- `ready` low for m cycles stretches the frame by exactly m cycles. It also causes at most 2 words to be fetched ahead.
- `ready` has no combinational path to `i_valid`. `ready` reaches `mem_rd_en` combinationally through `pop`.
- Reset values:
  - `busy`, `done`, `mem_rd_en`, `i_valid`, `o_eol`, `o_last` = 0.
  - `mem_addr`, `i_data` = 0.

## Structure
- Shared package `hog_pkg`: `PIX_W`, `IN_W`, `state_t` (IDLE/RUN/DRAIN).
- Sub-module `hog_skid_fifo`: 2-entry, width IN_W. Ports: push, pop, full, empty, `occ` count, head data; async reset.
- The top level holds the FSM, `raddr`, the outstanding flag, and the output word/column counters.

## Test plan
All scenarios use IMG_W=8, IMG_H=2, so NWORD=4 and WPR=2. The SRAM model returns word = 0x10101010*(addr+1).
- `ready`=1, `start` at cycle 0:
  - `i_valid` cycles 3–6 carry 0x10101010..0x40404040.
  - `o_eol` is high on words 1 and 3; `o_last` on word 3.
  - `done` pulses at cycle 7 and `busy` is low from cycle 7.
- `ready`=0 for cycles 3–8, then 1:
  - Exactly 2 reads are issued before the stall; `i_data` is held at 0x10101010.
  - All 4 words arrive in order and `done` pulses at cycle 13.
- `ready` toggles 1/0 every cycle:
  - No word is lost or duplicated and `o_last` is on the 4th handshake.
  - Peak FIFO occupancy is ≤2, and no read is issued while occ+outstanding−pop ≥2.
- `start` pulsed again at cycle 4 (busy), and again coincident with `done`:
  - Both are ignored and the frame completes once.
  - A new `start` at cycle 9 streams a second identical frame.
- `rst` asserted asynchronously at cycle 5:
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - After release, `start` streams a full frame from address 0.
